// File: rtl/led_pio_pkg.sv
// Register map shared by the LED PIO top level and anything that talks to it.
package led_pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLR    = 3'd2;
    localparam logic [2:0] ADDR_TOGGLE = 3'd3;
    localparam logic [2:0] ADDR_MASK   = 3'd4;
    localparam logic [2:0] ADDR_PERIOD = 3'd5;
    localparam logic [2:0] ADDR_STATUS = 3'd6;

endpackage

// File: rtl/blink_prescaler.sv
// Blink phase generator: phase toggles every period+1 cycles; period 0 parks it low.
module blink_prescaler #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] period,
    input  logic             clear,
    output logic             phase
);

    logic [CNT_W-1:0] count;

    // clear wins over a terminal count landing in the same cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            phase <= 1'b0;
        end else if (clear || (period == '0)) begin
            count <= '0;
            phase <= 1'b0;
        end else if (count == period) begin
            count <= '0;
            phase <= ~phase;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_pio_blink.sv
// LED PIO Avalon-MM slave with set/clear/toggle aliases and optional hardware blink.
// Blink logic (mask, period, prescaler, status) is built only when LED_PIO_BLINK_EN is defined.
module led_pio_blink
    import led_pio_pkg::*;
#(
    parameter int               WIDTH       = 9,
    parameter int               CNT_W       = 24,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic             read_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic             wr;
    logic             rd;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] data_next;
    logic [WIDTH-1:0] drive;
    logic [WIDTH-1:0] mask_view;
    logic [31:0]      period_view;
    logic [31:0]      status_view;
    logic [31:0]      rd_value;
    logic             unused_bits;

    assign wr = chipselect & ~write_n;
    assign rd = chipselect & ~read_n;
    assign wd = writedata[WIDTH-1:0];
    assign unused_bits = ^writedata;

    always_comb begin
        data_next = data;
        if (wr) begin
            case (address)
                ADDR_DATA:   data_next = wd;
                ADDR_SET:    data_next = data | wd;
                ADDR_CLR:    data_next = data & ~wd;
                ADDR_TOGGLE: data_next = data ^ wd;
                default:     data_next = data;
            endcase
        end
    end

`ifdef LED_PIO_BLINK_EN
    logic [WIDTH-1:0] mask;
    logic [CNT_W-1:0] period;
    logic             phase;
    logic             period_wr;

    assign period_wr = wr && (address == ADDR_PERIOD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask   <= '0;
            period <= '0;
        end else begin
            if (wr && (address == ADDR_MASK)) mask <= wd;
            if (period_wr) period <= writedata[CNT_W-1:0];
        end
    end

    // a period write restarts the blink from phase 0
    blink_prescaler #(
        .CNT_W(CNT_W)
    ) u_prescaler (
        .clk    (clk),
        .reset_n(reset_n),
        .period (period),
        .clear  (period_wr),
        .phase  (phase)
    );

    assign drive       = data & ~(mask & {WIDTH{phase}});
    assign mask_view   = mask;
    assign period_view = 32'(period);
    assign status_view = {31'd0, phase};
`else
    assign drive       = data;
    assign mask_view   = '0;
    assign period_view = '0;
    assign status_view = '0;
`endif

    // read mux sees pre-write register values, so wr+rd to one address returns old data
    always_comb begin
        rd_value = '0;
        case (address)
            ADDR_DATA:   rd_value = 32'(data);
            ADDR_MASK:   rd_value = 32'(mask_view);
            ADDR_PERIOD: rd_value = period_view;
            ADDR_STATUS: rd_value = status_view;
            default:     rd_value = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data     <= RESET_VALUE;
            out_port <= RESET_VALUE;
            readdata <= '0;
        end else begin
            data     <= data_next;
            out_port <= drive;
            readdata <= rd ? rd_value : 32'd0;
        end
    end

endmodule

// File: tb/tb_led_pio_blink.sv
// Bench for led_pio_blink: directed register scenarios plus random bus traffic against a reference model.
// Blink scenarios are exercised when LED_PIO_BLINK_EN is defined; otherwise the blink-absent map is checked.
module tb_led_pio_blink;
    import led_pio_pkg::*;

    localparam int               WIDTH       = 9;
    localparam int               CNT_W       = 24;
    localparam logic [WIDTH-1:0] RESET_VALUE = '0;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic [2:0]       address = '0;
    logic             chipselect = 1'b0;
    logic             write_n = 1'b1;
    logic             read_n = 1'b1;
    logic [31:0]      writedata = '0;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;

    int total = 0;
    int bad = 0;

    // reference model state: registers plus edges elapsed since the blink was restarted
    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] m_mask;
    logic [CNT_W-1:0] m_period;
    int unsigned      since;
    logic [31:0]      exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    led_pio_blink #(
        .WIDTH      (WIDTH),
        .CNT_W      (CNT_W),
        .RESET_VALUE(RESET_VALUE)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .read_n    (read_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // phase after k edges with period P is floor(k/(P+1)) mod 2
    function automatic logic m_phase();
`ifdef LED_PIO_BLINK_EN
        if (m_period == '0) return 1'b0;
        return ((since / (32'(m_period) + 32'd1)) % 32'd2) == 32'd1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [WIDTH-1:0] m_drive();
        return m_data & ~(m_mask & {WIDTH{m_phase()}});
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_data);
`ifdef LED_PIO_BLINK_EN
            3'd4:    return 32'(m_mask);
            3'd5:    return 32'(m_period);
            3'd6:    return {31'd0, m_phase()};
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_update(input logic w, input logic [2:0] a, input logic [31:0] d);
        logic [WIDTH-1:0] v;
        v = d[WIDTH-1:0];
        if (w && a == 3'd0) m_data = v;
        if (w && a == 3'd1) m_data = m_data | v;
        if (w && a == 3'd2) m_data = m_data & ~v;
        if (w && a == 3'd3) m_data = m_data ^ v;
`ifdef LED_PIO_BLINK_EN
        if (w && a == 3'd4) m_mask = v;
        if (w && a == 3'd5) begin
            m_period = d[CNT_W-1:0];
            since = 0;
        end else begin
            since++;
        end
`else
        since++;
`endif
    endtask

    task automatic m_reset();
        m_data   = RESET_VALUE;
        m_mask   = '0;
        m_period = '0;
        since    = 0;
    endtask

    // driver tasks: one bus cycle per call, sampled 1 time unit after the edge
    task automatic bus(input logic cs, input logic wn, input logic rn,
                       input logic [2:0] a, input logic [31:0] d);
        logic [WIDTH-1:0] exp_out;
        chipselect = cs;
        write_n    = wn;
        read_n     = rn;
        address    = a;
        writedata  = d;
        exp_q.push_back((cs && !rn) ? m_read(a) : 32'd0);
        exp_out = m_drive();
        @(posedge clk);
        #1;
        m_update(cs && !wn, a, d);
        check("readdata", readdata, exp_q.pop_front());
        check("out_port", 32'(out_port), 32'(exp_out));
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        bus(1'b1, 1'b0, 1'b1, a, d);
    endtask

    task automatic bus_rd(input logic [2:0] a);
        bus(1'b1, 1'b1, 1'b0, a, 32'd0);
    endtask

    task automatic bus_idle();
        bus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), $urandom);
    endtask

    task automatic do_reset(input string tag);
        #2;
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        read_n     = 1'b1;
        #1;
        check({tag, "_out"}, 32'(out_port), 32'(RESET_VALUE));
        check({tag, "_rd"}, readdata, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_reset();
    endtask

    initial begin
        int guard;
        m_reset();

        // reset state
        do_reset("reset");
        bus_idle();

        // set / clear / toggle sequence
        bus_wr(ADDR_DATA, 32'h0000_01A5);
        bus_wr(ADDR_SET, 32'h0000_0002);
        bus_wr(ADDR_CLR, 32'h0000_0001);
        bus_wr(ADDR_TOGGLE, 32'h0000_0100);
        bus_rd(ADDR_DATA);
        check("sct_read", readdata, 32'h0000_00A6);
        check("sct_out", 32'(out_port), 32'h0A6);
        bus_idle();
        check("rd_idle_zero", readdata, 32'd0);

        // width masking
        bus_wr(ADDR_DATA, 32'hFFFF_FFFF);
        bus_rd(ADDR_DATA);
        check("width_mask", readdata, 32'h0000_01FF);

        // write and read the same address together returns the old value
        bus(1'b1, 1'b0, 1'b0, ADDR_DATA, 32'h0000_0055);
        check("wr_rd_same", readdata, 32'h0000_01FF);
        bus_rd(ADDR_DATA);
        check("wr_rd_after", readdata, 32'h0000_0055);

        // unused addresses and chipselect gating
        bus_wr(3'd7, 32'hFFFF_FFFF);
        bus_rd(3'd7);
        bus(1'b0, 1'b0, 1'b0, ADDR_DATA, 32'h0000_0000);
        bus_rd(ADDR_DATA);
        check("cs_gate", readdata, 32'h0000_0055);

`ifdef LED_PIO_BLINK_EN
        // blinking: half-period of four cycles on the masked bits
        bus_wr(ADDR_DATA, 32'h0000_01FF);
        bus_wr(ADDR_MASK, 32'h0000_000F);
        bus_wr(ADDR_PERIOD, 32'd3);
        for (int i = 0; i < 20; i++) begin
            if (i % 5 == 4) bus_rd(ADDR_STATUS);
            else bus_idle();
            check("blink_val", 32'((out_port == 9'h1FF) || (out_port == 9'h1F0)), 32'd1);
        end

        // stopping mid-blink
        guard = 0;
        while (!m_phase() && guard < 16) begin
            bus_idle();
            guard++;
        end
        check("reach_phase1", 32'(m_phase()), 32'd1);
        bus_wr(ADDR_PERIOD, 32'd0);
        bus_idle();
        bus_idle();
        check("stop_out", 32'(out_port), 32'h1FF);
        bus_rd(ADDR_STATUS);
        check("stop_status", readdata, 32'd0);

        // reset while blinking
        bus_wr(ADDR_PERIOD, 32'd1);
        guard = 0;
        while (!m_phase() && guard < 16) begin
            bus_idle();
            guard++;
        end
        do_reset("rst_blink");
        bus_idle();
        bus_rd(ADDR_STATUS);
        check("rst_status", readdata, 32'd0);
        bus_rd(ADDR_PERIOD);
        check("rst_period", readdata, 32'd0);
`else
        // blink registers absent
        bus_wr(ADDR_DATA, 32'h0000_0133);
        bus_wr(ADDR_MASK, 32'h0000_00FF);
        bus_wr(ADDR_PERIOD, 32'd1);
        for (int i = 0; i < 6; i++) begin
            bus_idle();
            check("noblink_out", 32'(out_port), 32'h133);
        end
        bus_rd(ADDR_MASK);
        check("noblink_mask", readdata, 32'd0);
        bus_rd(ADDR_PERIOD);
        check("noblink_period", readdata, 32'd0);
        bus_rd(ADDR_STATUS);
        check("noblink_status", readdata, 32'd0);
`endif

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [2:0]  a;
            logic [31:0] d;
            a = 3'($urandom_range(0, 7));
            d = $urandom;
            if (a == ADDR_PERIOD) d = 32'($urandom_range(0, 5));
            bus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), a, d);
        end

        chipselect = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_pio_blink.md
LED_PIO_BLINK -- requirements
Module: led_pio_blink

Interface
REQ-001 The block SHALL have parameter WIDTH, default 9, giving the number of output bits (1..32).
REQ-002 The block SHALL have parameter CNT_W, default 24, giving the blink prescaler width (1..32).
REQ-003 The block SHALL have parameter RESET_VALUE, default 0, giving the reset value of the DATA register (WIDTH bits).
REQ-004 The block SHALL have the port clk, input, 1 bit: clock, with all state updated on its rising edge.
REQ-005 The block SHALL have the port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have the following Avalon-MM slave ports:
- address, input, 3 bits: register select.
- chipselect, input, 1 bit: slave select.
- write_n, input, 1 bit: write strobe, active-low.
- read_n, input, 1 bit: read strobe, active-low.
- writedata, input, 32 bits: write data.
- readdata, output, 32 bits: registered read data.
REQ-007 The block SHALL have the port out_port, output, WIDTH bits: registered LED drive.

Function
REQ-008 wr SHALL be defined as chipselect & ~write_n, and rd SHALL be defined as chipselect & ~read_n.
REQ-009 On wr, the register map SHALL behave as follows (only writedata[WIDTH-1:0] is used for WIDTH-bit registers; upper bits are ignored):
- addr 0 DATA: load.
- addr 1 SET: data |= wd.
- addr 2 CLR: data &= ~wd.
- addr 3 TOGGLE: data ^= wd.
- addr 4 BLINK_MASK: load.
- addr 5 PERIOD: load writedata[CNT_W-1:0].
- addr 6, 7: write ignored.
REQ-010 Reads SHALL have 1-cycle latency: readdata is registered from address at the rd edge and is zero-extended to 32 bits.
REQ-011 Read values SHALL be as follows:
- addr 0: DATA.
- addr 1-3: 0.
- addr 4: BLINK_MASK.
- addr 5: PERIOD.
- addr 6 STATUS: bit0 = phase, other bits 0.
- addr 7: 0.
REQ-012 readdata SHALL be 0 in any cycle following a cycle with no rd.
REQ-013 The prescaler SHALL behave as follows:
- If PERIOD==0: counter held at 0, phase held at 0.
- Otherwise: counter increments each cycle; when counter==PERIOD, counter<=0 and phase toggles.
- Result: phase half-period = PERIOD+1 cycles.
REQ-014 A PERIOD write SHALL clear counter and phase in the same edge, taking priority over any terminal count in that cycle.
REQ-015 out_port SHALL be registered as DATA & ~(BLINK_MASK & {WIDTH{phase}}), so a register write at edge N is visible on out_port after edge N+1.
REQ-016 Simultaneous wr and rd to the same address SHALL return the pre-write value.
REQ-017 Each access SHALL complete in one cycle with no wait states (no waitrequest).

Reset
REQ-018 While reset_n is low, the block SHALL asynchronously set:
- DATA = RESET_VALUE.
- BLINK_MASK = 0.
- PERIOD = 0.
- counter = 0.
- phase = 0.
- readdata = 0.
- out_port = RESET_VALUE.
REQ-019 Reset asserted mid-blink SHALL take effect immediately, with no residual phase on release.

Configuration
REQ-020 When macro LED_PIO_BLINK_EN is defined, the blink logic (BLINK_MASK, PERIOD, prescaler, STATUS) SHALL be compiled in.
REQ-021 When LED_PIO_BLINK_EN is undefined, the blink logic SHALL be absent: addresses 4-6 read 0 and ignore writes, and out_port is registered DATA.

Structure
REQ-022 Package led_pio_pkg SHALL hold the register address constants (ADDR_DATA..ADDR_STATUS).
REQ-023 The prescaler counter/phase SHALL be a single sub-module, blink_prescaler (parameter CNT_W; inputs period, clear; output phase).

Verification
REQ-024 The bench SHALL cover reset: reset_n low with WIDTH=9 and RESET_VALUE=0 -> out_port=0x000 and readdata=0.
REQ-025 The bench SHALL cover set/clear/toggle: write DATA 0x1A5, SET 0x002, CLR 0x001, TOGGLE 0x100 -> read addr0 returns 0x000000A6 one cycle after rd, and out_port=0x0A6.
REQ-026 The bench SHALL cover blinking: DATA 0x1FF, MASK 0x00F, PERIOD 3 -> out_port alternates 0x1FF/0x1F0 every 4 cycles, with STATUS bit0 tracking the phase.
REQ-027 The bench SHALL cover disabling mid-blink: write PERIOD 0 while phase=1 -> out_port returns to 0x1FF within 2 cycles, and STATUS reads 0.
REQ-028 The bench SHALL cover width masking: write DATA 0xFFFFFFFF -> read addr0 returns 0x000001FF.
REQ-029 The bench SHALL cover the configuration without LED_PIO_BLINK_EN: write MASK 0x0FF, PERIOD 1 -> reads of addr4/addr5 return 0 and out_port equals DATA.
